dso_trigger: RTL and testbench
==============================

# dso_trigger

Edge-trigger detector for the DSO acquisition path. Compares each signed 8-bit ADC sample against a programmable signed threshold. Emits a single-cycle `edge_flag` pulse when the waveform crosses the threshold in the selected direction. Hysteresis-based arming rejects noise chatter around the level. The capture/record controller consumes `edge_flag` to time-stamp the trigger point.

## Interface
- `WIDTH`, default 8: sample and level width; two's-complement signed.
- `HYST`, default 4: hysteresis depth in LSBs, 0..2^(WIDTH-1)-1.
- `HOLDOFF`, default 0: cycles after a trigger during which re-arming is blocked; 0 disables holdoff.

- `clk`, in, 1: sole clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `signal`, in, WIDTH: ADC sample, signed, valid every cycle.
- `level`, in, WIDTH: trigger threshold, signed; may change at any time.
- `rising_edge`, in, 1: 1 selects rising-edge trigger, 0 selects falling-edge trigger.
- `edge_flag`, out, 1: registered one-cycle trigger pulse.
- `armed`, out, 1: registered; high while the detector is in ARMED.

## Operation
- All comparisons are signed. `level ± HYST` is computed at WIDTH+1 bits, so an out-of-range threshold never wraps.
- **Rising edge:**
  - Arm condition: `signal < level − HYST`.
  - Fire condition: `signal >= level`.
- **Falling edge:**
  - Arm condition: `signal > level + HYST`.
  - Fire condition: `signal <= level`.
- **States and transitions:**
  - IDLE → ARMED when the arm condition holds.
  - ARMED → fire when the fire condition holds. Pulse `edge_flag`, then go to HOLDOFF if `HOLDOFF > 0`, otherwise to IDLE.
  - HOLDOFF counts `HOLDOFF` cycles, then → IDLE. Arm conditions are ignored during HOLDOFF.
- Arm has priority within a cycle. From IDLE, a sample that satisfies the arm condition arms; firing needs a later sample. A single sample can never both arm and fire.
- **Polarity change:** a change on `rising_edge` (detected against its registered copy) forces IDLE, clears the holdoff counter, and suppresses `edge_flag` that cycle.
- Changing `level` does not disarm the detector; new comparisons apply immediately.
- **Noise rejection:** after a fire, samples within (level − HYST, level + HYST) cannot re-arm. With level 0 and HYST 4, chatter between −3 and +3 produces exactly one trigger.

## Timing
- `edge_flag` goes high on the clock edge that samples a firing `signal` value, for exactly one cycle. Latency is 1 clock from the sample's presence at the input.
- `armed` changes on the same edge as the corresponding state transition.
- Minimum spacing between pulses:
  - 2 cycles (arm sample, then fire sample) when `HOLDOFF = 0`.
  - `HOLDOFF + 2` cycles otherwise.
- Reset, asynchronous: state IDLE, `edge_flag` = 0, `armed` = 0, holdoff counter = 0, registered polarity = 1.
- Reset asserted mid-operation aborts any ARMED or HOLDOFF state immediately. The first pulse after reset release requires a fresh arm.

## Configuration
- `DSO_TRIGGER_HYST_EN` defined: hysteresis is active as described above, using `HYST`.
- Macro undefined:
  - `HYST` is treated as 0, so the arm condition becomes the strict inverse of the fire condition (`signal < level` for rising, `signal > level` for falling).
  - Noise around the level then produces multiple triggers. This mode is intended for clean digital sources only.

## Structure
- Shared package `dso_pkg` holds:
  - the state enum (IDLE, ARMED, HOLDOFF);
  - the sample type `signed [WIDTH-1:0]`;
  - the default constants for HYST and HOLDOFF.
- One natural sub-module, `trig_compare`: purely combinational. Inputs are `signal`, `level`, `rising_edge` and the hysteresis depth; outputs are `arm_cond` and `fire_cond`, with the widened signed arithmetic.
- The top-level block holds the FSM, the holdoff counter, the polarity register and the output registers.

## Test plan
- **Rising trigger with noise rejection.** `DSO_TRIGGER_HYST_EN` defined, level 0, HYST 4, rising. Feed the repeating sequence −43, −23, −13, −3, 3, −3, −2, 2, −2, −3, −1, 2, 3, −3, −2. Required: exactly one `edge_flag` pulse per period, one cycle after the sample 3 that follows −3; no pulses on the later 2 or 3.
- **Same sequence with the macro undefined.** Required: pulses one cycle after each non-negative sample (3, 2, 2) that follows a negative one.
- **Falling trigger.** level 10, HYST 4, falling. Feed 40, 20, 10, 12, 9. Required: one pulse one cycle after sample 10; sample 9 produces no pulse.
- **Holdoff.** HOLDOFF 5, rising, level 0. Feed alternating −50 / 50 every cycle. Required: pulses spaced exactly 7 cycles apart, with `armed` low during holdoff.
- **Polarity flip.** Arm on −50 with rising selected, flip `rising_edge` to 0, then feed 50. Required: no pulse, `armed` low.
- **Reset mid-operation.** While ARMED, assert `rst_n` low between clock edges. Required: `armed` and `edge_flag` go to 0 immediately; no pulse after release until a fresh arm-then-fire sequence.

Source files
------------

// File: rtl/dso_pkg.sv
// Shared types and default constants for the DSO edge-trigger path.
package dso_pkg;

    localparam int SAMPLE_WIDTH    = 8;
    localparam int HYST_DEFAULT    = 4;
    localparam int HOLDOFF_DEFAULT = 0;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_HOLDOFF
    } trig_state_t;

endpackage

// File: rtl/trig_compare.sv
// Signed threshold comparator producing arm/fire conditions; arithmetic is
// widened by one bit so that level +/- hyst never wraps.
module trig_compare #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] signal,
    input  logic signed [WIDTH-1:0] level,
    input  logic                    rising_edge,
    input  logic        [WIDTH-1:0] hyst,
    output logic                    arm_cond,
    output logic                    fire_cond
);

    logic signed [WIDTH:0] sig_w;
    logic signed [WIDTH:0] lvl_w;
    logic signed [WIDTH:0] hyst_w;
    logic signed [WIDTH:0] lo_w;
    logic signed [WIDTH:0] hi_w;

    assign sig_w  = {signal[WIDTH-1], signal};
    assign lvl_w  = {level[WIDTH-1], level};
    assign hyst_w = {1'b0, hyst};
    assign lo_w   = lvl_w - hyst_w;
    assign hi_w   = lvl_w + hyst_w;

    always_comb begin
        arm_cond  = 1'b0;
        fire_cond = 1'b0;
        if (rising_edge) begin
            arm_cond  = (sig_w < lo_w);
            fire_cond = (sig_w >= lvl_w);
        end else begin
            arm_cond  = (sig_w > hi_w);
            fire_cond = (sig_w <= lvl_w);
        end
    end

endmodule

// File: rtl/dso_trigger.sv
// Edge-trigger detector with hysteresis arming and optional holdoff.
// Hysteresis is enabled only when DSO_TRIGGER_HYST_EN is defined.
module dso_trigger
    import dso_pkg::*;
#(
    parameter int WIDTH   = SAMPLE_WIDTH,
    parameter int HYST    = HYST_DEFAULT,
    parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] signal,
    input  logic signed [WIDTH-1:0] level,
    input  logic                    rising_edge,
    output logic                    edge_flag,
    output logic                    armed
);

`ifdef DSO_TRIGGER_HYST_EN
    localparam int HYST_EFF = HYST;
`else
    // Without hysteresis the arm condition is the strict inverse of fire.
    localparam int HYST_EFF = HYST * 0;
`endif

    localparam int                 CNT_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);
    localparam logic [WIDTH-1:0]   HYST_VEC = WIDTH'(HYST_EFF);

    trig_state_t      state;
    logic [CNT_W-1:0] holdoff_cnt;
    logic             pol_q;
    logic             arm_cond;
    logic             fire_cond;

    trig_compare #(
        .WIDTH(WIDTH)
    ) u_compare (
        .signal     (signal),
        .level      (level),
        .rising_edge(rising_edge),
        .hyst       (HYST_VEC),
        .arm_cond   (arm_cond),
        .fire_cond  (fire_cond)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            edge_flag   <= 1'b0;
            armed       <= 1'b0;
            holdoff_cnt <= '0;
            pol_q       <= 1'b1;
        end else begin
            pol_q     <= rising_edge;
            edge_flag <= 1'b0;
            // A polarity change invalidates any arming done in the old direction.
            if (rising_edge != pol_q) begin
                state       <= S_IDLE;
                armed       <= 1'b0;
                holdoff_cnt <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (arm_cond) begin
                            state <= S_ARMED;
                            armed <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (fire_cond) begin
                            edge_flag <= 1'b1;
                            armed     <= 1'b0;
                            if (HOLDOFF > 0) begin
                                state       <= S_HOLDOFF;
                                holdoff_cnt <= CNT_LOAD;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_HOLDOFF: begin
                        if (holdoff_cnt == '0) begin
                            state <= S_IDLE;
                        end else begin
                            holdoff_cnt <= holdoff_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        armed <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dso_trigger.sv
// Scoreboard bench for dso_trigger: directed samples push expected outputs,
// a negedge monitor pops and compares them. Honors DSO_TRIGGER_HYST_EN.
module tb_dso_trigger;
    import dso_pkg::*;

    typedef struct {
        logic  sel;
        logic  exp_ef;
        logic  exp_arm;
        string name;
    } exp_item_t;

    logic    clk;
    logic    rst_n;
    sample_t signal;
    sample_t level;
    logic    rising_edge;
    logic    ef_a, armed_a;
    logic    ef_h, armed_h;

    int pass_count  = 0;
    int total_count = 0;

    exp_item_t exp_q[$];
    exp_item_t mon_item;

    logic [0:14] p1_ef;
    logic [0:14] p1_arm;
    int          p1_sig [15] = '{-43, -23, -13, -3, 3, -3, -2, 2, -2, -3, -1, 2, 3, -3, -2};

    dso_trigger #(.WIDTH(8), .HYST(4), .HOLDOFF(0)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .signal     (signal),
        .level      (level),
        .rising_edge(rising_edge),
        .edge_flag  (ef_a),
        .armed      (armed_a)
    );

    dso_trigger #(.WIDTH(8), .HYST(4), .HOLDOFF(5)) dut_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .signal     (signal),
        .level      (level),
        .rising_edge(rising_edge),
        .edge_flag  (ef_h),
        .armed      (armed_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic act_ef, input logic act_arm,
                               input logic exp_ef, input logic exp_arm);
        total_count++;
        if (act_ef === exp_ef && act_arm === exp_arm) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: edge_flag=%b armed=%b, required edge_flag=%b armed=%b",
                     name, act_ef, act_arm, exp_ef, exp_arm);
        end
    endtask

    // Drive one sample, then record what the selected DUT must show after the edge.
    task automatic applyStimulus(input logic sel, input int s, input logic exp_ef,
                                 input logic exp_arm, input string name);
        exp_item_t it;
        signal = 8'(s);
        @(posedge clk);
        #1;
        it.sel     = sel;
        it.exp_ef  = exp_ef;
        it.exp_arm = exp_arm;
        it.name    = name;
        exp_q.push_back(it);
    endtask

    task automatic resetDut(input logic sel, input string name);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        if (sel) checkOutput(name, ef_h, armed_h, 1'b0, 1'b0);
        else     checkOutput(name, ef_a, armed_a, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_item = exp_q.pop_front();
            if (mon_item.sel)
                checkOutput(mon_item.name, ef_h, armed_h, mon_item.exp_ef, mon_item.exp_arm);
            else
                checkOutput(mon_item.name, ef_a, armed_a, mon_item.exp_ef, mon_item.exp_arm);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef DSO_TRIGGER_HYST_EN
        p1_ef  = 15'b000010000000000;
        p1_arm = 15'b111100000000000;
`else
        p1_ef  = 15'b000010010001000;
        p1_arm = 15'b111101101110011;
`endif
        rst_n       = 1'b0;
        signal      = '0;
        level       = '0;
        rising_edge = 1'b1;
        #12;
        checkOutput("reset_a", ef_a, armed_a, 1'b0, 1'b0);
        checkOutput("reset_h", ef_h, armed_h, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Rising trigger around level 0, two periods of chatter.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 15; i++) begin
                applyStimulus(1'b0, p1_sig[i], p1_ef[i], p1_arm[i],
                              $sformatf("rise_p%0d_s%0d", p, i));
            end
        end

        // Falling trigger at level 10; first sample absorbs the polarity resync.
        level       = 8'sd10;
        rising_edge = 1'b0;
        resetDut(1'b0, "fall_reset");
        applyStimulus(1'b0, 10, 1'b0, 1'b0, "fall_polsync");
        applyStimulus(1'b0, 40, 1'b0, 1'b1, "fall_arm40");
        applyStimulus(1'b0, 20, 1'b0, 1'b1, "fall_hold20");
        applyStimulus(1'b0, 10, 1'b1, 1'b0, "fall_fire10");
`ifdef DSO_TRIGGER_HYST_EN
        applyStimulus(1'b0, 12, 1'b0, 1'b0, "fall_noarm12");
        applyStimulus(1'b0, 9,  1'b0, 1'b0, "fall_nofire9");
`else
        applyStimulus(1'b0, 12, 1'b0, 1'b1, "fall_arm12");
        applyStimulus(1'b0, 9,  1'b1, 1'b0, "fall_fire9");
`endif

        // Holdoff of 5: arm samples inside holdoff are ignored, pulses 7 cycles apart.
        level       = 8'sd0;
        rising_edge = 1'b1;
        resetDut(1'b1, "hold_reset");
        applyStimulus(1'b1, -50, 1'b0, 1'b1, "hold_arm0");
        applyStimulus(1'b1, 50,  1'b1, 1'b0, "hold_fire0");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, -50, 1'b0, 1'b0, $sformatf("hold_block%0d", i));
        end
        applyStimulus(1'b1, -50, 1'b0, 1'b1, "hold_arm1");
        applyStimulus(1'b1, 50,  1'b1, 1'b0, "hold_fire1");
        applyStimulus(1'b1, -50, 1'b0, 1'b0, "hold_after1");

        // Polarity flip while armed forces IDLE with no pulse.
        resetDut(1'b0, "flip_reset");
        applyStimulus(1'b0, -50, 1'b0, 1'b1, "flip_arm");
        rising_edge = 1'b0;
        applyStimulus(1'b0, 50, 1'b0, 1'b0, "flip_cycle");
        applyStimulus(1'b0, 0,  1'b0, 1'b0, "flip_after");

        // Asynchronous reset mid-operation.
        rising_edge = 1'b1;
        resetDut(1'b0, "rstmid_reset");
        applyStimulus(1'b0, -50, 1'b0, 1'b1, "rstmid_arm");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_armed_clr", ef_a, armed_a, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 50,  1'b0, 1'b0, "rstmid_nofire");
        applyStimulus(1'b0, -50, 1'b0, 1'b1, "rstmid_rearm");
        applyStimulus(1'b0, 50,  1'b1, 1'b0, "rstmid_fire");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_flag_clr", ef_a, armed_a, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 50, 1'b0, 1'b0, "rstmid_nofire2");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total_count++;
            $display("[TB] FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
